encode_initial_conf: RTL and testbench

- Host-side assembler for the 512-bit CGRA initial-configuration word.
- Collects the run fields through 32-bit register writes into a staging area.
- On commit, packs the fields into the fixed 512-bit layout and offers the word to the configuration consumer through a valid/ready handshake.
- Keeps a count of delivered words and flags rejected commits.

---
 rtl/encode_initial_conf.sv | 111 +++++++++++
 tb/tb_encode_initial_conf.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/encode_initial_conf.sv
// Stages run fields through 32-bit writes and packs them into the 512-bit CGRA initial-configuration word.
// Define ENCODE_INITIAL_CONF_CHECK_EN to also reject commits with num_conf==0 or start_loop>=num_conf.
module encode_initial_conf #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             commit,
  output logic [511:0]     initial_conf,
  output logic             conf_valid,
  input  logic             conf_ready,
  output logic [6:0]       staged_mask,
  output logic             commit_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] conf_count
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      stage_q [7];
  logic [31:0]      stage_d [7];
  logic [6:0]       mask_q, mask_d;
  logic [511:0]     conf_q, conf_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic wr_valid;
  logic xfer;
  logic slot_free;
  logic value_ok;
  logic accept;

  assign wr_valid = wr_en && (wr_addr != 3'd7);
  assign xfer     = (state_q == PENDING) && conf_ready;
  assign slot_free = (state_q == IDLE) || xfer;

  // Staging view that already includes this cycle's write, so a same-cycle commit sees it.
  always_comb begin
    stage_d = stage_q;
    mask_d  = mask_q;
    for (int unsigned i = 0; i < 7; i++) begin
      if (wr_valid && (wr_addr == 3'(i))) begin
        stage_d[i] = wr_data;
        mask_d[i]  = 1'b1;
      end
    end
  end

`ifdef ENCODE_INITIAL_CONF_CHECK_EN
  assign value_ok = (stage_d[5] != 32'd0) && (stage_d[6] < stage_d[5]);
`else
  assign value_ok = 1'b1;
`endif

  assign accept = commit && (mask_d == 7'h7F) && slot_free && value_ok;

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    count_d = count_q;
    err_d   = err_q;

    if (xfer) begin
      count_d = count_q + CNT_W'(1);
    end

    if (accept) begin
      state_d = PENDING;
      conf_d  = {288'd0, stage_d[6], stage_d[5], stage_d[4],
                 stage_d[3], stage_d[2], stage_d[1], stage_d[0]};
    end else if (xfer) begin
      state_d = IDLE;
    end

    if (commit && !accept) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '{default: '0};
      mask_q  <= '0;
      conf_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      mask_q  <= mask_d;
      conf_q  <= conf_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign initial_conf = conf_q;
  assign conf_valid   = (state_q == PENDING);
  assign staged_mask  = mask_q;
  assign commit_err   = err_q;
  assign conf_count   = count_q;

endmodule

// File: tb/tb_encode_initial_conf.sv
// Directed plus randomized bench for encode_initial_conf against a field-level reference model.
module tb_encode_initial_conf;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             commit;
  logic [511:0]     initial_conf;
  logic             conf_valid;
  logic             conf_ready;
  logic [6:0]       staged_mask;
  logic             commit_err;
  logic             err_clr;
  logic [CNT_W-1:0] conf_count;

  encode_initial_conf #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .initial_conf (initial_conf),
    .conf_valid   (conf_valid),
    .conf_ready   (conf_ready),
    .staged_mask  (staged_mask),
    .commit_err   (commit_err),
    .err_clr      (err_clr),
    .conf_count   (conf_count)
  );

  always #5 clk = ~clk;

  // Reference model: named run fields, a pending flag and the offered word.
  logic [63:0]      m_data_in, m_data_out;
  logic [31:0]      m_cicles, m_num_conf, m_start_loop;
  logic [6:0]       m_mask;
  logic             m_pending;
  logic [511:0]     m_word;
  logic             m_err;
  logic [CNT_W-1:0] m_count;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [511:0] build_word();
    logic [511:0] w;
    w = '0;
    w[63:0]    = m_data_in;
    w[127:64]  = m_data_out;
    w[159:128] = m_cicles;
    w[191:160] = m_num_conf;
    w[223:192] = m_start_loop;
    return w;
  endfunction

  task automatic model_step();
    bit ok;
    if (!rst_n) begin
      m_data_in = '0; m_data_out = '0; m_cicles = '0; m_num_conf = '0; m_start_loop = '0;
      m_mask = '0; m_pending = 0; m_word = '0; m_err = 0; m_count = '0;
      return;
    end
    if (wr_en && wr_addr != 3'd7) begin
      case (wr_addr)
        3'd0: m_data_in[31:0]   = wr_data;
        3'd1: m_data_in[63:32]  = wr_data;
        3'd2: m_data_out[31:0]  = wr_data;
        3'd3: m_data_out[63:32] = wr_data;
        3'd4: m_cicles          = wr_data;
        3'd5: m_num_conf        = wr_data;
        default: m_start_loop   = wr_data;
      endcase
      m_mask = m_mask | (7'd1 << wr_addr);
    end
    ok = (m_mask == 7'h7F) && (!m_pending || conf_ready);
`ifdef ENCODE_INITIAL_CONF_CHECK_EN
    if (m_num_conf == 0 || m_start_loop >= m_num_conf) ok = 0;
`endif
    if (m_pending && conf_ready) m_count = m_count + 1'b1;
    if (commit && ok) begin
      m_word    = build_word();
      m_pending = 1;
    end else if (m_pending && conf_ready) begin
      m_pending = 0;
    end
    if (commit && !ok) m_err = 1;
    else if (err_clr)  m_err = 0;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("conf_valid",   512'(conf_valid),  512'(m_pending));
    check("initial_conf", initial_conf,      m_word);
    check("staged_mask",  512'(staged_mask), 512'(m_mask));
    check("commit_err",   512'(commit_err),  512'(m_err));
    check("conf_count",   512'(conf_count),  512'(m_count));
  endtask

  task automatic drive(input logic rn, input logic we, input logic [2:0] a, input logic [31:0] d,
                       input logic cm, input logic rdy, input logic clr);
    rst_n = rn; wr_en = we; wr_addr = a; wr_data = d; commit = cm; conf_ready = rdy; err_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    drive(1, 1, a, d, 0, 0, 0);
    tick();
  endtask

  logic [511:0] held;
  logic [31:0]  plan [7];

  initial begin
    plan = '{32'h10, 32'h0, 32'h8, 32'h0, 32'h20, 32'h4, 32'h1};

    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Full staging and commit, consumer stalls, then accepts.
    for (int i = 0; i < 7; i++) wr(3'(i), plan[i]);
    drive(1, 0, 0, 0, 1, 0, 0);
    tick();
    check("first_valid",  512'(conf_valid), 512'(1));
    check("field_in",     512'(initial_conf[63:0]),    512'(64'h10));
    check("field_out",    512'(initial_conf[127:64]),  512'(64'h8));
    check("field_cicles", 512'(initial_conf[159:128]), 512'(32'h20));
    check("field_conf",   512'(initial_conf[191:160]), 512'(32'h4));
    check("field_start",  512'(initial_conf[223:192]), 512'(32'h1));
    check("field_zero",   512'(initial_conf[511:224]), 512'(0));
    held = initial_conf;
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_stable", initial_conf, held);
    end
    drive(1, 0, 0, 0, 0, 1, 0);
    tick();
    check("deliver_valid", 512'(conf_valid), 512'(0));
    check("deliver_count", 512'(conf_count), 512'(1));

    // Partial staging rejects the commit.
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 6; i++) wr(3'(i), plan[i]);
    drive(1, 0, 0, 0, 1, 0, 0);
    tick();
    check("partial_err",   512'(commit_err),  512'(1));
    check("partial_valid", 512'(conf_valid),  512'(0));
    check("partial_mask",  512'(staged_mask), 512'(7'h3F));
    drive(1, 0, 0, 0, 0, 0, 1);
    tick();
    check("err_clr", 512'(commit_err), 512'(0));

    // Back-to-back commit with same-cycle write.
    wr(3'd6, plan[6]);
    drive(1, 0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 1, 3'd5, 32'h9, 1, 1, 0);
    tick();
    check("b2b_count", 512'(conf_count), 512'(1));
    check("b2b_valid", 512'(conf_valid), 512'(1));
    check("b2b_conf",  512'(initial_conf[191:160]), 512'(32'h9));

    // Commit while stalled is rejected.
    held = initial_conf;
    drive(1, 0, 0, 0, 1, 0, 0);
    tick();
    check("stall_commit_err",  512'(commit_err), 512'(1));
    check("stall_commit_word", initial_conf, held);

    // Reset mid-handshake; reserved address write.
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("rst_valid", 512'(conf_valid),  512'(0));
    check("rst_count", 512'(conf_count),  512'(0));
    check("rst_mask",  512'(staged_mask), 512'(0));
    wr(3'd7, 32'hDEAD);
    check("addr7_mask", 512'(staged_mask), 512'(0));

`ifdef ENCODE_INITIAL_CONF_CHECK_EN
    plan[6] = 32'h4;
    for (int i = 0; i < 7; i++) wr(3'(i), plan[i]);
    drive(1, 0, 0, 0, 1, 0, 0);
    tick();
    check("chk_reject_err",   512'(commit_err), 512'(1));
    check("chk_reject_valid", 512'(conf_valid), 512'(0));
    drive(1, 1, 3'd6, 32'h3, 1, 0, 1);
    tick();
    check("chk_accept_valid", 512'(conf_valid), 512'(1));
    check("chk_accept_err",   512'(commit_err), 512'(0));
    drive(1, 0, 0, 0, 0, 1, 0);
    tick();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1), a, d,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
